sensor_packetizer_mc: RTL and testbench
=======================================

Name: sensor_packetizer_mc

Overview:
- Parametrised multi-channel successor to the fixed three-sensor packet path.
- Each of NUM_CH sensor channels pushes timestamped samples into its own FIFO.
- A round-robin arbiter selects a channel; the block serialises a framed byte packet (header, sensor ID, length, timestamp, data, XOR checksum) onto a valid/ready byte stream toward the UART/TX FIFO.
- Power mode gates channel acceptance and packet start.

Parameters:
- NUM_CH, 3, number of sensor channels (1..8).
- DATA_W, 16, sample width in bits; multiple of 8, range 8..32.
- TS_W, 32, timestamp width in bits; multiple of 8, range 8..32.
- FIFO_DEPTH, 8, entries per channel FIFO; power of two, at least 2.
- HEADER_BYTE, 8'hA5, first byte of every packet.
- BASE_ID, 8'h01, sensor_id of channel 0; channel i sends BASE_ID+i.
- LOW_MASK, all ones, per-channel enable bitmap applied in PWR_LOW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_valid  in  NUM_CH  per-channel sample valid.
- ch_data  in  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready  out  NUM_CH  per-channel accept.
- pwr_mode  in  2  power_mode_e encoding: NORMAL, LOW, SLEEP, DEEP.
- tx_data  out  8  packet byte.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  downstream accept.
- busy  out  1  packet in progress.
- overflow  out  NUM_CH  sticky per-channel drop flag.
- clear_overflow  in  1  clears all overflow bits.

Behaviour:
- Clock, reset and power mode:
  - Single clock clk; reset rst_n is asynchronous, active-low.
  - Reset values: tx_valid=0, tx_data=0, busy=0, overflow=0, all FIFOs empty, timestamp=0, FSM in IDLE, RR pointer=NUM_CH-1 (channel 0 wins first).
  - Timestamp counter: TS_W bits, +1 per cycle, wraps to 0. It is frozen while pwr_mode=DEEP.
  - ch_ready[i] = !full[i] && allow[i], combinational from registered state.
  - allow[i]: NORMAL → 1; LOW → LOW_MASK[i]; SLEEP and DEEP → 0.
- Enqueue:
  - A push happens on an edge where ch_valid[i] && ch_ready[i].
  - The stored entry is {ch_data slice, timestamp value sampled at that edge, pre-increment}.
- Overflow:
  - overflow[i] sets on any edge with ch_valid[i] && allow[i] && full[i]. The sample is dropped.
  - clear_overflow clears all bits. If a set and a clear occur in the same cycle, the set wins.
  - Samples offered while allow[i]=0 are ignored and do not set overflow.
- Arbitration (IDLE only):
  - A packet starts if some FIFO is non-empty and pwr_mode is not SLEEP or DEEP.
  - Grant goes to the first non-empty channel after the RR pointer, modulo NUM_CH.
  - On grant, in the same edge: pop that FIFO into a packet register, update the pointer to the granted channel, load the HDR byte, assert tx_valid and busy.
  - Latency: a sample accepted at edge E into an empty system gives HDR valid after edge E+1.
  - A pop and a push on the same FIFO in the same cycle are both honoured; the count is unchanged.
- FSM states and byte sequence, MSB-first:
  - IDLE.
  - HDR: HEADER_BYTE.
  - ID: BASE_ID+grant.
  - LEN_H, LEN_L: 16-bit DATA_W/8.
  - TS: TS_W/8 bytes.
  - DATA: DATA_W/8 bytes.
  - CSUM: XOR of every preceding byte of the packet.
- Packet length is 5+TS_W/8+DATA_W/8 bytes (11 at defaults).
- TS and DATA use a byte-index counter.
- Handshake:
  - The FSM advances only on an edge with tx_valid && tx_ready.
  - tx_data stays stable while tx_valid=1 && !tx_ready.
  - tx_valid never drops mid-packet.
- After CSUM is accepted:
  - Next state is IDLE. tx_valid=0 and busy=0 for at least one cycle.
  - Minimum packet-to-packet gap is one idle cycle.
- Power-mode change mid-packet: the current packet completes unaltered; only the next start is blocked.
- Reset mid-packet: the packet is aborted immediately, with no partial CSUM, and all outputs return to reset values.

Test Plan:
- Reset, then ch0 push 16'h1234 on the edge where timestamp=5, tx_ready=1 → bytes A5 01 00 02 00 00 00 05 12 34 85; busy low after the last byte.
- ch0, ch1 and ch2 push in the same cycle → packets emitted with IDs 01, 02, 03 in order. Then push ch2 and ch0 together → ID 01 (ch0) is served before 03.
- Toggle tx_ready 1-0-0-1 during the TS bytes → no byte lost or duplicated, and tx_data holds while stalled.
- Fill ch1 with 8 pushes while tx_ready=0, then push a 9th → ch_ready[1]=0 and overflow[1]=1. Assert clear_overflow together with a 10th push → overflow stays 1; the next clear alone → 0.
- pwr_mode=LOW with LOW_MASK=3'b101 → ch_ready[1]=0 and ch1 pushes are ignored without setting overflow. Switch to SLEEP mid-packet → the packet finishes and no new packet starts although FIFOs are non-empty.
- Assert rst_n=0 during the DATA byte → next cycle tx_valid=0 and busy=0; after release the FIFOs are empty and timestamp restarts at 0.

Source files
------------

// File: rtl/sensor_packetizer_mc_if.sv
// Byte stream from the packetizer toward the UART/TX FIFO.
interface sensor_packetizer_mc_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sensor_packetizer_mc.sv
// Multi-channel sensor packetizer: per-channel timestamped FIFOs, round-robin
// arbitration, framed byte packets with XOR checksum on a valid/ready stream.
module sensor_packetizer_mc #(
    parameter int unsigned       NUM_CH      = 3,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       TS_W        = 32,
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter logic [7:0]        HEADER_BYTE = 8'hA5,
    parameter logic [7:0]        BASE_ID     = 8'h01,
    parameter logic [NUM_CH-1:0] LOW_MASK    = '1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [1:0]               pwr_mode,
    sensor_packetizer_mc_if.master   tx,
    output logic                     busy,
    output logic [NUM_CH-1:0]        overflow,
    input  logic                     clear_overflow
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned EW        = DATA_W + TS_W;
    localparam logic [2:0]  TS_LAST   = 3'(TS_W / 8 - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_W / 8 - 1);
    localparam logic [15:0] PKT_LEN   = 16'(DATA_W / 8);

    typedef enum logic [1:0] {PWR_NORMAL, PWR_LOW, PWR_SLEEP, PWR_DEEP} power_mode_e;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_ID, S_LEN_H, S_LEN_L, S_TS, S_DATA, S_CSUM} state_e;

    power_mode_e              pmode;
    state_e                   state, state_nx;
    logic [TS_W-1:0]          ts;
    logic [NUM_CH-1:0]        allow, full, empty, push, pop;
    logic [NUM_CH-1:0][EW-1:0] head;
    logic [CW-1:0]            rr, gnt, cand;
    logic                     found, start, fire, seg_last;
    logic [DATA_W-1:0]        pkt_data;
    logic [TS_W-1:0]          pkt_ts;
    logic [7:0]               pkt_id, csum, tx_byte;
    logic [2:0]               idx;

    assign pmode = power_mode_e'(pwr_mode);

    always_comb begin
        case (pmode)
            PWR_NORMAL: allow = '1;
            PWR_LOW:    allow = LOW_MASK;
            default:    allow = '0;
        endcase
    end

    assign ch_ready = ~full & allow;
    assign push     = ch_valid & ch_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [AW:0]   wr_ptr, rd_ptr;

        assign full[g]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign empty[g] = (wr_ptr == rd_ptr);
        assign pop[g]   = start && (gnt == CW'(g));
        assign head[g]  = mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr[AW-1:0]] <= {ch_data[g*DATA_W +: DATA_W], ts};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            overflow <= '0;
        end else begin
            if (pmode != PWR_DEEP) ts <= ts + 1'b1;
            // a same-cycle set overrides the clear
            overflow <= (overflow & ~{NUM_CH{clear_overflow}}) | (ch_valid & allow & full);
        end
    end

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CW'((32'(rr) + k) % NUM_CH);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    assign start    = (state == S_IDLE) && found && (pmode == PWR_NORMAL || pmode == PWR_LOW);
    assign fire     = tx.tx_valid && tx.tx_ready;
    assign seg_last = (state == S_TS && idx == TS_LAST) || (state == S_DATA && idx == DATA_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_HDR;
            S_HDR:   if (fire)  state_nx = S_ID;
            S_ID:    if (fire)  state_nx = S_LEN_H;
            S_LEN_H: if (fire)  state_nx = S_LEN_L;
            S_LEN_L: if (fire)  state_nx = S_TS;
            S_TS:    if (fire && seg_last) state_nx = S_DATA;
            S_DATA:  if (fire && seg_last) state_nx = S_CSUM;
            S_CSUM:  if (fire)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // TS and DATA are shifted left per accepted byte, so the MSB byte is always on top
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_HDR:   tx_byte = HEADER_BYTE;
            S_ID:    tx_byte = pkt_id;
            S_LEN_H: tx_byte = PKT_LEN[15:8];
            S_LEN_L: tx_byte = PKT_LEN[7:0];
            S_TS:    tx_byte = pkt_ts[TS_W-1 -: 8];
            S_DATA:  tx_byte = pkt_data[DATA_W-1 -: 8];
            S_CSUM:  tx_byte = csum;
            default: tx_byte = 8'h00;
        endcase
    end

    assign tx.tx_data  = tx_byte;
    assign tx.tx_valid = (state != S_IDLE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_data <= '0;
            pkt_ts   <= '0;
            pkt_id   <= '0;
            csum     <= '0;
            idx      <= '0;
            rr       <= CW'(NUM_CH - 1);
        end else if (start) begin
            {pkt_data, pkt_ts} <= head[gnt];
            pkt_id <= BASE_ID + 8'(gnt);
            csum   <= '0;
            idx    <= '0;
            rr     <= gnt;
        end else if (fire) begin
            csum <= csum ^ tx_byte;
            if (state == S_TS)   pkt_ts   <= pkt_ts << 8;
            if (state == S_DATA) pkt_data <= pkt_data << 8;
            if (state == S_TS || state == S_DATA) idx <= seg_last ? 3'd0 : idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_sensor_packetizer_mc.sv
// Directed bench for sensor_packetizer_mc: expected bytes are queued at stimulus
// time and a negedge monitor pops and compares every accepted tx byte.
module tb_sensor_packetizer_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_valid;
    logic [47:0] ch_data;
    logic [2:0]  ch_ready;
    logic [1:0]  pwr_mode;
    logic        busy;
    logic [2:0]  overflow;
    logic        clear_overflow;

    sensor_packetizer_mc_if tx_if ();

    sensor_packetizer_mc #(
        .NUM_CH(3), .DATA_W(16), .TS_W(32), .FIFO_DEPTH(8),
        .HEADER_BYTE(8'hA5), .BASE_ID(8'h01), .LOW_MASK(3'b101)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .pwr_mode(pwr_mode), .tx(tx_if), .busy(busy),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          bytes_seen = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] tb_ts = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input logic [7:0] id, input logic [31:0] ts, input logic [15:0] d);
        logic [7:0] b [10];
        logic [7:0] cs;
        b = '{8'hA5, id, 8'h00, 8'h02, ts[31:24], ts[23:16], ts[15:8], ts[7:0], d[15:8], d[7:0]};
        cs = 8'h00;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(b[i]);
            cs = cs ^ b[i];
        end
        exp_q.push_back(cs);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 400 && bytes_seen < n; i++) tick();
        if (bytes_seen < n) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_bytes: got %0d bytes expected %0d", bytes_seen, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_valid = '0;
        clear_overflow = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // timestamp the DUT will sample on the next edge, readable at posedge+1
    initial forever begin
        @(posedge clk);
        if (!rst_n) tb_ts = '0;
        else if (pwr_mode != 2'd3) tb_ts = tb_ts + 1;
    end

    initial begin : monitor
        logic       stalled;
        logic [7:0] held;
        logic [7:0] exp;
        stalled = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_hold", {23'd0, tx_if.tx_valid, tx_if.tx_data}, {24'd1, held});
                if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h expected none", tx_if.tx_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check("tx_byte", {24'd0, tx_if.tx_data}, {24'd0, exp});
                    end
                    bytes_seen++;
                    stalled = 1'b0;
                end else if (tx_if.tx_valid === 1'b1) begin
                    stalled = 1'b1;
                    held = tx_if.tx_data;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        logic [7:0]  t1 [11];
        logic [7:0]  t6 [11];
        logic [31:0] ts0;
        int          s;
        t1 = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h12, 8'h34, 8'h85};
        t6 = '{8'hA5, 8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF, 8'hF5};
        rst_n = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        pwr_mode = 2'd0;
        clear_overflow = 1'b0;
        tx_if.tx_ready = 1'b1;
        repeat (2) tick();
        check("rst_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_if.tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {29'd0, overflow}, 32'd0);
        check("rst_ch_ready", {29'd0, ch_ready}, 32'd7);
        rst_n = 1'b1;

        // single sample at timestamp 5
        repeat (5) tick();
        foreach (t1[i]) exp_q.push_back(t1[i]);
        s = bytes_seen;
        ch_valid = 3'b001;
        ch_data[15:0] = 16'h1234;
        tick();
        ch_valid = '0;
        check("t1_lat_before", {31'd0, tx_if.tx_valid}, 32'd0);
        tick();
        check("t1_lat_hdr", {23'd0, tx_if.tx_valid, tx_if.tx_data}, {23'd0, 1'b1, 8'hA5});
        wait_bytes(s + 11);
        check("t1_gap_busy", {31'd0, busy}, 32'd0);
        check("t1_gap_valid", {31'd0, tx_if.tx_valid}, 32'd0);

        // round robin from reset, then ch0 ahead of ch2
        do_reset();
        s = bytes_seen;
        ts0 = tb_ts;
        ch_valid = 3'b111;
        ch_data = {16'h3333, 16'h2222, 16'h1111};
        expect_pkt(8'h01, ts0, 16'h1111);
        expect_pkt(8'h02, ts0, 16'h2222);
        expect_pkt(8'h03, ts0, 16'h3333);
        tick();
        ch_valid = '0;
        wait_bytes(s + 33);
        s = bytes_seen;
        ts0 = tb_ts;
        ch_valid = 3'b101;
        ch_data = {16'hC2C2, 16'h0000, 16'hA0A0};
        expect_pkt(8'h01, ts0, 16'hA0A0);
        expect_pkt(8'h03, ts0, 16'hC2C2);
        tick();
        ch_valid = '0;
        wait_bytes(s + 22);

        // back-pressure during the TS bytes
        s = bytes_seen;
        ts0 = tb_ts;
        ch_valid = 3'b010;
        ch_data[31:16] = 16'h5A5A;
        expect_pkt(8'h02, ts0, 16'h5A5A);
        tick();
        ch_valid = '0;
        wait_bytes(s + 5);
        tx_if.tx_ready = 1'b0;
        tick();
        tick();
        tx_if.tx_ready = 1'b1;
        tick();
        tx_if.tx_ready = 1'b0;
        tick();
        tx_if.tx_ready = 1'b1;
        wait_bytes(s + 11);

        // fill ch1 behind a stalled packet, overflow and clear priority
        s = bytes_seen;
        tx_if.tx_ready = 1'b0;
        ts0 = tb_ts;
        ch_valid = 3'b001;
        ch_data[15:0] = 16'h0F0F;
        expect_pkt(8'h01, ts0, 16'h0F0F);
        tick();
        ch_valid = 3'b010;
        for (int k = 0; k < 8; k++) begin
            ch_data[31:16] = 16'h1000 + 16'(k);
            expect_pkt(8'h02, tb_ts, ch_data[31:16]);
            tick();
        end
        check("t4_full_ready", {31'd0, ch_ready[1]}, 32'd0);
        check("t4_no_ovf_yet", {29'd0, overflow}, 32'd0);
        ch_data[31:16] = 16'hDEAD;
        tick();
        check("t4_ovf_set", {29'd0, overflow}, 32'd2);
        clear_overflow = 1'b1;
        tick();
        check("t4_set_wins", {29'd0, overflow}, 32'd2);
        ch_valid = '0;
        tick();
        check("t4_cleared", {29'd0, overflow}, 32'd0);
        clear_overflow = 1'b0;
        tx_if.tx_ready = 1'b1;
        wait_bytes(s + 99);

        // LOW mask, then SLEEP mid-packet
        do_reset();
        pwr_mode = 2'd1;
        #1;
        check("t5_low_ready", {29'd0, ch_ready}, 32'd5);
        s = bytes_seen;
        ts0 = tb_ts;
        ch_valid = 3'b111;
        ch_data = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        expect_pkt(8'h01, ts0, 16'h0A0A);
        expect_pkt(8'h03, ts0, 16'h0C0C);
        tick();
        ch_valid = '0;
        check("t5_no_ovf", {29'd0, overflow}, 32'd0);
        wait_bytes(s + 3);
        pwr_mode = 2'd2;
        #1;
        check("t5_sleep_ready", {29'd0, ch_ready}, 32'd0);
        wait_bytes(s + 11);
        repeat (20) tick();
        check("t5_sleep_busy", {31'd0, busy}, 32'd0);
        check("t5_sleep_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        pwr_mode = 2'd0;
        wait_bytes(s + 22);

        // reset in the middle of DATA
        s = bytes_seen;
        ts0 = tb_ts;
        ch_valid = 3'b111;
        ch_data = {16'h1C1C, 16'h1B1B, 16'h1A1A};
        expect_pkt(8'h01, ts0, 16'h1A1A);
        tick();
        ch_valid = '0;
        wait_bytes(s + 8);
        check("t6_in_data", {24'd0, tx_if.tx_data}, 32'h1A);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_data", {24'd0, tx_if.tx_data}, 32'd0);
        tick();
        tick();
        s = bytes_seen;
        rst_n = 1'b1;
        ch_valid = 3'b100;
        ch_data[47:32] = 16'hBEEF;
        foreach (t6[i]) exp_q.push_back(t6[i]);
        tick();
        ch_valid = '0;
        wait_bytes(s + 11);
        repeat (10) tick();

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("drain_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
